mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Iterative RV32M multiply/divide unit; the multi-cycle companion to the single-cycle ALU in EX.
//  Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with valid/ready handshakes on request and response.
//  Retires BITS_PER_CYCLE quotient/multiplier bits per cycle. Divide-by-zero and signed overflow take a fast path.
// PARAMETERS
//  XLEN            32  operand/result width
//  BITS_PER_CYCLE  1   iteration bits per cycle; one of 1, 2, 4, and must divide XLEN
// PORTS
//  clk_i        in   1     clock, rising edge
//  rst_i        in   1     reset, asynchronous, active-high
//  flush_i      in   1     kill any in-flight op (pipeline flush)
//  req_valid_i  in   1     request valid
//  req_ready_o  out  1     unit can accept a request (state IDLE)
//  req_op_i     in   3     op, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  req_a_i      in   XLEN  rs1 operand
//  req_b_i      in   XLEN  rs2 operand
//  resp_valid_o out  1     result valid
//  resp_ready_i in   1     consumer accepts result
//  resp_data_o  out  XLEN  result
//  busy_o       out  1     state != IDLE
// BEHAVIOUR
//  Reset (async, rst_i=1):
//   - state=IDLE; resp_valid_o=0; resp_data_o=0; busy_o=0; all datapath regs and counter = 0
//   - req_ready_o=1 once reset is released
//  FSM IDLE -> BUSY -> DONE -> IDLE. req_ready_o = (state==IDLE), combinational from state.
//   IDLE: accept when req_valid_i & req_ready_o & ~flush_i; latch op and operands.
//     - Special case: go straight to DONE.
//     - Otherwise: go to BUSY with cnt = XLEN/BITS_PER_CYCLE.
//   BUSY: one step per cycle; cnt decrements; at cnt==1 the final step is written, then go to DONE.
//   DONE: resp_valid_o=1 and resp_data_o held stable until resp_ready_i; leave on the handshake.
//     - No new request is accepted in the handshake cycle (IDLE first).
//  Latency (accept edge to first resp_valid_o cycle):
//   - normal ops: XLEN/BITS_PER_CYCLE + 1 cycles (33 for defaults)
//   - special cases: 1 cycle
//  Signedness: operands are converted to magnitudes; the unsigned core runs on them; the result is negated at the end.
//   - MUL, MULH: both operands signed
//   - MULHSU: a signed, b unsigned
//   - DIV, REM: both operands signed
//   - quotient sign = sa^sb; remainder sign = sa
//  Multiply: 2*XLEN-bit shift-add product.
//   - MUL returns product[XLEN-1:0]
//   - MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN], taken after sign correction over all 2*XLEN bits
//  Divide: restoring shift-subtract; quotient and remainder are formed together.
//  Special cases, spec-mandated and no trap:
//   - b==0: DIV/DIVU -> all-ones; REM/REMU -> a
//   - DIV with a==MIN_INT and b==-1: quotient MIN_INT; REM -> 0
//  Flush:
//   - flush_i=1 in any state -> IDLE next edge; resp_valid_o=0 next cycle; the result is discarded
//   - flush_i beats a same-cycle request: no accept
//   - flush_i in DONE together with resp_ready_i: counts as a flush; the consumer must ignore that beat
//  Reset mid-op: immediate abandon; outputs return to reset values asynchronously.
//  Width rules: cnt width $clog2(XLEN/BITS_PER_CYCLE+1); all internal sums XLEN+1 bits (no silent overflow).
// STRUCTURE
//  Package mdu_pkg:
//   - mdu_op_e enum (8 ops above); mdu_state_e enum {IDLE, BUSY, DONE}
//   - helpers is_div(op), is_signed_a(op), is_signed_b(op), returns_hi(op)
//  Sub-module mdu_step (combinational):
//   - inputs: accumulator, operand, mode (mul/div)
//   - output: next accumulator after BITS_PER_CYCLE unrolled shift-add or shift-subtract steps
//   - mdu_iter owns FSM, counter, sign handling, special cases and handshake
// TESTING
//  1 MUL a=7, b=0xFFFFFFFD -> 0xFFFFFFEB; resp_valid_o exactly 33 cycles after accept (BITS_PER_CYCLE=1), 9 cycles with BITS_PER_CYCLE=4
//  2 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF
//  3 DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2
//  4 DIVU 5/0 -> 0xFFFFFFFF and REMU 5,0 -> 5, both in 1 cycle; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, 1 cycle
//  5 Backpressure: resp_ready_i=0 for 10 cycles in DONE -> resp_valid_o and resp_data_o stable, req_ready_o=0; then one handshake -> IDLE
//  6 flush_i at BUSY cycle 5 -> IDLE next edge, no response; rst_i pulsed mid-BUSY -> all outputs at reset values immediately, next op correct

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
// Holds the op and state enums plus small predicates on the op code.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdu_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_MULHSU) || (op == OP_DIV) ||
           (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic returns_hi(input mdu_op_e op);
    return ~op[2] & (op != OP_MUL);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// Combinational iteration kernel: BITS_PER_CYCLE unrolled steps of
// shift-add multiply or restoring shift-subtract divide.
// Ports: i_acc {hi,lo} accumulator, i_opnd magnitude operand,
//        i_div selects divide, o_acc next accumulator.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  input  logic              i_div,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] w_acc;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem;
  logic [XLEN:0]     w_dif;

  // Multiply: hi accumulates, lo holds the multiplier and
  // receives product bits as the pair shifts right.
  // Divide: hi is the partial remainder, lo shifts the
  // dividend out and the quotient in.
  always_comb begin
    w_acc = i_acc;
    w_sum = '0;
    w_rem = '0;
    w_dif = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (i_div) begin
        w_rem = {w_acc[2*XLEN-1:XLEN], w_acc[XLEN-1]};
        w_dif = w_rem - {1'b0, i_opnd};
        if (!w_dif[XLEN])
          w_acc = {w_dif[XLEN-1:0], w_acc[XLEN-2:0], 1'b1};
        else
          w_acc = {w_rem[XLEN-1:0], w_acc[XLEN-2:0], 1'b0};
      end else begin
        w_sum = {1'b0, w_acc[2*XLEN-1:XLEN]} +
                (w_acc[0] ? {1'b0, i_opnd} : '0);
        w_acc = {w_sum, w_acc[XLEN-1:1]};
      end
    end
  end

  assign o_acc = w_acc;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response.
// Ports: clk_i, rst_i, flush_i, req_* (valid/ready/op/a/b), resp_* (valid/ready/data), busy_o.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_data_o,
  output logic            busy_o
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        r_state;
  mdu_op_e           r_op;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_neg;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_data;
  logic              r_valid;

  mdu_op_e           w_op;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_ma;
  logic [XLEN-1:0]   w_mb;
  logic              w_bz;
  logic              w_ovf;
  logic              w_spec;
  logic [XLEN-1:0]   w_spec_data;
  logic              w_neg;
  logic [2*XLEN-1:0] w_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_dres;
  logic [XLEN-1:0]   w_dres_s;
  logic [XLEN-1:0]   w_result;

  assign w_op   = mdu_op_e'(req_op_i);
  assign w_sa   = is_signed_a(w_op) & req_a_i[XLEN-1];
  assign w_sb   = is_signed_b(w_op) & req_b_i[XLEN-1];
  assign w_ma   = w_sa ? -req_a_i : req_a_i;
  assign w_mb   = w_sb ? -req_b_i : req_b_i;
  assign w_bz   = (req_b_i == '0);
  assign w_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                  (req_a_i == MIN_INT) && (req_b_i == '1);
  assign w_spec = is_div(w_op) & (w_bz | w_ovf);
  assign w_neg  = is_rem(w_op) ? w_sa : (w_sa ^ w_sb);

  // Divide-by-zero wins over overflow (b=-1 is nonzero anyway).
  always_comb begin
    w_spec_data = '0;
    if (w_bz)
      w_spec_data = is_rem(w_op) ? req_a_i : '1;
    else
      w_spec_data = is_rem(w_op) ? '0 : MIN_INT;
  end

  mdu_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_acc  (r_acc),
    .i_opnd (r_b),
    .i_div  (is_div(r_op)),
    .o_acc  (w_next)
  );

  // Sign is applied over the full product so MULH* see a
  // correct high half.
  assign w_prod   = r_neg ? -w_next : w_next;
  assign w_dres   = is_rem(r_op) ? w_next[2*XLEN-1:XLEN]
                                 : w_next[XLEN-1:0];
  assign w_dres_s = r_neg ? -w_dres : w_dres;
  assign w_result = is_div(r_op)     ? w_dres_s :
                    returns_hi(r_op) ? w_prod[2*XLEN-1:XLEN] :
                                       w_prod[XLEN-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_op    <= OP_MUL;
      r_acc   <= '0;
      r_b     <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_op  <= w_op;
            r_b   <= w_mb;
            r_neg <= w_neg;
            r_acc <= {{XLEN{1'b0}}, w_ma};
            if (w_spec) begin
              r_data  <= w_spec_data;
              r_valid <= 1'b1;
              r_cnt   <= '0;
              r_state <= DONE;
            end else begin
              r_cnt   <= CW'(STEPS);
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_acc <= w_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_data  <= w_result;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (resp_ready_i) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (r_state == IDLE);
  assign busy_o       = (r_state != IDLE);
  assign resp_valid_o = r_valid;
  assign resp_data_o  = r_data;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV32M cases plus random ops
// against a plain-arithmetic reference, with handshake, flush and reset checks.
module tb_mdu_iter;

  localparam int XLEN = 32;
  localparam int BPC  = 1;
  localparam logic [31:0] MINI = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_iter #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BPC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .busy_o       (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    longint as_ = longint'($signed(a));
    longint bs_ = longint'($signed(b));
    longint au  = longint'({32'b0, a});
    longint bu  = longint'({32'b0, b});
    longint p;
    int     ia  = $signed(a);
    int     ib  = $signed(b);
    logic [31:0] r;
    logic ovf = (a == MINI) && (b == 32'hFFFF_FFFF);
    p = 0;
    r = '0;
    case (op)
      3'd0: begin p = as_ * bs_; r = p[31:0];  end
      3'd1: begin p = as_ * bs_; r = p[63:32]; end
      3'd2: begin p = as_ * bu;  r = p[63:32]; end
      3'd3: begin p = au * bu;   r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                ovf ? MINI : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    logic sdiv = (op == 3'd4) || (op == 3'd6);
    if (op[2] && (b == 0 ||
        (sdiv && a == MINI && b == 32'hFFFF_FFFF)))
      return 1;
    return XLEN / BPC + 1;
  endfunction

  // Issue one op, measure latency, hold backpressure, handshake.
  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int hold);
    int lat;
    logic [31:0] d0;
    @(negedge clk);
    chk({tag, ":ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ":lat"}, 32'(lat), 32'(exp_lat(op, a, b)));
    chk({tag, ":data"}, resp_data, ref_model(op, a, b));
    d0 = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ":hold_v"}, 32'(resp_valid), 32'd1);
      chk({tag, ":hold_d"}, resp_data, d0);
      chk({tag, ":hold_rdy"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({tag, ":post_v"}, 32'(resp_valid), 32'd0);
    chk({tag, ":post_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    #2;
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    chk("mul_const", ref_model(3'd0, 32'd7, 32'hFFFF_FFFD),
        32'hFFFF_FFEB);
    run_op("mulh", 3'd1, MINI, MINI, 0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 0);
    run_op("divu0", 3'd5, 32'd5, 32'd0, 0);
    run_op("remu0", 3'd7, 32'd5, 32'd0, 0);
    run_op("div0", 3'd4, 32'hFFFF_FFF0, 32'd0, 0);
    run_op("rem0", 3'd6, 32'hFFFF_FFF0, 32'd0, 0);
    run_op("divovf", 3'd4, MINI, 32'hFFFF_FFFF, 0);
    run_op("removf", 3'd6, MINI, 32'hFFFF_FFFF, 0);
    run_op("divuovf", 3'd5, MINI, 32'hFFFF_FFFF, 0);
    run_op("bp", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);

    // Flush during BUSY, with a request in the flush cycle.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd0;
    req_a = 32'd3;
    req_b = 32'd4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(resp_valid), 32'd0);
    chk("flush_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush = 1'b0;
    chk("flush_beats_req", 32'(busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      chk("flush_noresp", 32'(resp_valid), 32'd0);
    end

    // Reset pulse mid-BUSY.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd5;
    req_a = 32'd1000;
    req_b = 32'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_data", resp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 3'd6, 32'hFFFF_FF9C, 32'd7, 0);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = MINI; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rand", op, a, b, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
